// File: rtl/apb_completer_mem_if.sv
// apb_completer_mem_if: APB3 bus signals between the team's master and one completer
interface apb_completer_mem_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );
    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_completer_mem.sv
// apb_completer_mem: APB3 completer with a word-addressed memory, programmable wait states and error response
module apb_completer_mem #(
    parameter int          DEPTH       = 128,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input logic                PCLK,
    input logic                PRESET,
    apb_completer_mem_if.slave bus
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [31:0]   addr, addr_n, wdata, wdata_n, rdata, rdata_n;
    logic          write, write_n, ready, ready_n, slverr, slverr_n, mem_we;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   offset, word;
    logic          err;
    logic [AW-1:0] idx;
    // Decode works on the latched setup-phase address so mid-access changes are ignored
    assign offset = addr - BASE_ADDR;
    assign word   = offset >> 2;
    assign idx    = word[AW-1:0];
    assign err    = (addr < BASE_ADDR) || (word >= 32'(DEPTH)) || (addr[1:0] != 2'b00);
    assign bus.PRDATA  = rdata;
    assign bus.PREADY  = ready;
    assign bus.PSLVERR = slverr;
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        addr_n   = addr;
        wdata_n  = wdata;
        write_n  = write;
        ready_n  = 1'b0;
        slverr_n = 1'b0;
        rdata_n  = 32'h0;
        mem_we   = 1'b0;
        case (state)
            IDLE: if (bus.PSEL && !bus.PENABLE) begin
                addr_n  = bus.PADDR;
                wdata_n = bus.PWDATA;
                write_n = bus.PWRITE;
                cnt_n   = 4'(WAIT_CYCLES);
                state_n = WAIT;
            end
            WAIT: begin
                if (!(bus.PSEL && bus.PENABLE)) begin
                    state_n = IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    ready_n  = 1'b1;
                    slverr_n = err;
                    mem_we   = write && !err;
                    rdata_n  = (write || err) ? 32'h0 : mem[idx];
                    state_n  = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            addr   <= 32'h0;
            wdata  <= 32'h0;
            write  <= 1'b0;
            ready  <= 1'b0;
            slverr <= 1'b0;
            rdata  <= 32'h0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr   <= addr_n;
            wdata  <= wdata_n;
            write  <= write_n;
            ready  <= ready_n;
            slverr <= slverr_n;
            rdata  <= rdata_n;
        end
    end
    // Storage has no reset; writes only ever come from the error-free final WAIT cycle
    always_ff @(posedge PCLK) begin
        if (mem_we) mem[idx] <= wdata;
    end
endmodule

// File: tb/tb_apb_completer_mem.sv
// tb_apb_completer_mem: directed APB transfers against a 2-wait-state and a 0-wait-state completer
module tb_apb_completer_mem;
    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int prev_start = 0;
    logic [31:0] rd;
    logic er;
    int acc;
    int spacing;
    int seen;
    apb_completer_mem_if i2 ();
    apb_completer_mem_if i0 ();
    apb_completer_mem #(.DEPTH(128), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u2 (.PCLK(PCLK), .PRESET(PRESET), .bus(i2));
    apb_completer_mem #(.DEPTH(128), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u0 (.PCLK(PCLK), .PRESET(PRESET), .bus(i0));
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic drive(input int d, input logic s, input logic e, input logic w, input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            i0.PSEL = s; i0.PENABLE = e; i0.PWRITE = w; i0.PADDR = a; i0.PWDATA = wd;
        end else begin
            i2.PSEL = s; i2.PENABLE = e; i2.PWRITE = w; i2.PADDR = a; i2.PWDATA = wd;
        end
    endtask
    function automatic logic rdy(input int d);
        return d == 0 ? i0.PREADY : i2.PREADY;
    endfunction
    // Address and data are scrambled after the first access cycle; the completer must use latched values
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] r, output logic e, output int n);
        @(negedge PCLK);
        prev_start = start_cyc;
        start_cyc = cyc;
        drive(d, 1'b1, 1'b0, w, a, wd);
        @(negedge PCLK);
        drive(d, 1'b1, 1'b1, w, a, wd);
        n = 1;
        while (!rdy(d) && n < 20) begin
            @(negedge PCLK);
            drive(d, 1'b1, 1'b1, w, ~a, ~wd);
            n++;
        end
        r = d == 0 ? i0.PRDATA : i2.PRDATA;
        e = d == 0 ? i0.PSLVERR : i2.PSLVERR;
    endtask
    task automatic idle(input int d);
        @(negedge PCLK);
        drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask
    initial begin
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge PCLK);
        chk("rst_pready2", 32'(i2.PREADY), 32'd0);
        chk("rst_pslverr2", 32'(i2.PSLVERR), 32'd0);
        chk("rst_prdata2", i2.PRDATA, 32'h0);
        chk("rst_pready0", 32'(i0.PREADY), 32'd0);
        PRESET = 1'b0;
        xfer(2, 1'b1, 32'h20, 32'hCAFEF00D, rd, er, acc);
        chk("w20_acc", 32'(acc), 32'd4);
        idle(2);
        @(negedge PCLK);
        drive(2, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0BADF00D);
        @(negedge PCLK);
        drive(2, 1'b1, 1'b1, 1'b1, 32'h20, 32'h0BADF00D);
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("midrst_pready", 32'(i2.PREADY), 32'd0);
        chk("midrst_pslverr", 32'(i2.PSLVERR), 32'd0);
        chk("midrst_prdata", i2.PRDATA, 32'h0);
        PRESET = 1'b0;
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge PCLK);
        xfer(2, 1'b0, 32'h20, 32'h0, rd, er, acc);
        chk("r20_kept", rd, 32'hCAFEF00D);
        PRESET = 1'b1;
        #1;
        chk("asyncrst_pready", 32'(i2.PREADY), 32'd0);
        chk("asyncrst_prdata", i2.PRDATA, 32'h0);
        @(negedge PCLK);
        PRESET = 1'b0;
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        xfer(2, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, acc);
        chk("w10_acc", 32'(acc), 32'd4);
        chk("w10_err", 32'(er), 32'd0);
        chk("w10_prdata", rd, 32'h0);
        @(negedge PCLK);
        chk("w10_ready_one_cycle", 32'(i2.PREADY), 32'd0);
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        xfer(2, 1'b0, 32'h10, 32'h0, rd, er, acc);
        chk("r10_data", rd, 32'hDEADBEEF);
        chk("r10_acc", 32'(acc), 32'd4);
        idle(2);
        xfer(2, 1'b1, 32'h0, 32'h1, rd, er, acc);
        xfer(2, 1'b1, 32'h4, 32'h2, rd, er, acc);
        spacing = start_cyc - prev_start;
        chk("b2b_spacing_w", 32'(spacing), 32'd5);
        xfer(2, 1'b0, 32'h0, 32'h0, rd, er, acc);
        chk("b2b_r0", rd, 32'h1);
        spacing = start_cyc - prev_start;
        chk("b2b_spacing_r0", 32'(spacing), 32'd5);
        xfer(2, 1'b0, 32'h4, 32'h0, rd, er, acc);
        chk("b2b_r4", rd, 32'h2);
        spacing = start_cyc - prev_start;
        chk("b2b_spacing_r4", 32'(spacing), 32'd5);
        xfer(2, 1'b0, 32'h200, 32'h0, rd, er, acc);
        chk("r200_err", 32'(er), 32'd1);
        chk("r200_ready", 32'(i2.PREADY), 32'd1);
        chk("r200_prdata", rd, 32'h0);
        xfer(2, 1'b0, 32'h13, 32'h0, rd, er, acc);
        chk("r13_err", 32'(er), 32'd1);
        chk("r13_prdata", rd, 32'h0);
        xfer(2, 1'b1, 32'h202, 32'hFFFFFFFF, rd, er, acc);
        chk("w202_err", 32'(er), 32'd1);
        xfer(2, 1'b0, 32'h0, 32'h0, rd, er, acc);
        chk("after_w202_r0", rd, 32'h1);
        chk("after_w202_err", 32'(er), 32'd0);
        xfer(2, 1'b0, 32'h4, 32'h0, rd, er, acc);
        chk("after_w202_r4", rd, 32'h2);
        xfer(2, 1'b1, 32'h8, 32'h11111111, rd, er, acc);
        idle(2);
        @(negedge PCLK);
        drive(2, 1'b1, 1'b0, 1'b1, 32'h8, 32'hAAAA5555);
        @(negedge PCLK);
        drive(2, 1'b1, 1'b1, 1'b1, 32'h8, 32'hAAAA5555);
        @(negedge PCLK);
        drive(2, 1'b0, 1'b1, 1'b1, 32'h8, 32'hAAAA5555);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            if (i2.PREADY) seen++;
        end
        chk("abort_no_ready", 32'(seen), 32'd0);
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        xfer(2, 1'b0, 32'h8, 32'h0, rd, er, acc);
        chk("abort_r8_old", rd, 32'h11111111);
        idle(2);
        xfer(0, 1'b1, 32'h1FC, 32'h12345678, rd, er, acc);
        chk("w1fc_acc", 32'(acc), 32'd2);
        chk("w1fc_err", 32'(er), 32'd0);
        xfer(0, 1'b0, 32'h1FC, 32'h0, rd, er, acc);
        chk("r1fc_data", rd, 32'h12345678);
        chk("r1fc_acc", 32'(acc), 32'd2);
        chk("r1fc_err", 32'(er), 32'd0);
        xfer(0, 1'b0, 32'h200, 32'h0, rd, er, acc);
        chk("r200_w0_err", 32'(er), 32'd1);
        idle(0);
        repeat (2) @(negedge PCLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
